// File: rtl/wallace_mul8_seq_if.sv
// ----------------------------------------------------------------------------
// wallace_mul8_seq_if: operand, result and 4x4 core buses of wallace_mul8_seq. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface wallace_mul8_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  core_a;
  logic [3:0]  core_b;
  logic [7:0]  core_prod;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] prod;

  modport master (
    output in_valid, a, b, out_ready, core_prod,
    input  in_ready, core_a, core_b, out_valid, prod
  );

  modport slave (
    input  in_valid, a, b, out_ready, core_prod,
    output in_ready, core_a, core_b, out_valid, prod
  );
endinterface

`default_nettype wire

// File: rtl/wallace_mul8_seq.sv
// ----------------------------------------------------------------------------
// wallace_mul8_seq: unsigned 8x8 multiply in four passes over an external 4x4 core. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wallace_mul8_seq #(
  parameter int unsigned CORE_LAT  = 0,
  parameter bit          ZERO_SKIP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  wallace_mul8_seq_if.slave  bus,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] C_LAT = CORE_LAT[1:0];

  state_t      state_q, state_d;
  logic [1:0]  pass_q, pass_d;
  logic [1:0]  wait_q, wait_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  op_a_q, op_a_d;
  logic [7:0]  op_b_q, op_b_d;

  logic [3:0]  sel_a, sel_b, shift;
  logic        in_ready_w, out_valid_w;
  logic [3:0]  core_a_w, core_b_w;

  // Pass order: lo*lo, hi*lo, lo*hi, hi*hi with their partial-product weights.
  always_comb begin
    sel_a = op_a_q[3:0];
    sel_b = op_b_q[3:0];
    shift = 4'd0;
    case (pass_q)
      2'd0: begin sel_a = op_a_q[3:0]; sel_b = op_b_q[3:0]; shift = 4'd0; end
      2'd1: begin sel_a = op_a_q[7:4]; sel_b = op_b_q[3:0]; shift = 4'd4; end
      2'd2: begin sel_a = op_a_q[3:0]; sel_b = op_b_q[7:4]; shift = 4'd4; end
      default: begin sel_a = op_a_q[7:4]; sel_b = op_b_q[7:4]; shift = 4'd8; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pass_d      = pass_q;
    wait_d      = wait_q;
    acc_d       = acc_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    in_ready_w  = 1'b0;
    out_valid_w = 1'b0;
    core_a_w    = 4'd0;
    core_b_w    = 4'd0;
    case (state_q)
      ST_IDLE: begin
        in_ready_w = 1'b1;
        if (bus.in_valid) begin
          op_a_d = bus.a;
          op_b_d = bus.b;
          acc_d  = 16'd0;
          pass_d = 2'd0;
          wait_d = 2'd0;
          if (ZERO_SKIP && ((bus.a == 8'd0) || (bus.b == 8'd0)))
            state_d = ST_DONE;
          else
            state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        core_a_w = sel_a;
        core_b_w = sel_b;
        if (wait_q == C_LAT) begin
          acc_d  = acc_q + ({8'd0, bus.core_prod} << shift);
          wait_d = 2'd0;
          pass_d = pass_q + 2'd1;
          if (pass_q == 2'd3)
            state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      ST_DONE: begin
        out_valid_w = 1'b1;
        if (bus.out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pass_q  <= 2'd0;
      wait_q  <= 2'd0;
      acc_q   <= 16'd0;
      op_a_q  <= 8'd0;
      op_b_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      wait_q  <= wait_d;
      acc_q   <= acc_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  // The accumulator doubles as the result register, so prod holds through IDLE.
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.core_a    = core_a_w;
  assign bus.core_b    = core_b_w;
  assign bus.prod      = acc_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

`default_nettype wire
